dp_cu_arbiter: RTL and testbench
================================

Name: dp_cu_arbiter

Overview:
- Shares one DP_CU datapath/control unit between two requesters.
- DP_CU computes 3-bit add/sub/and/xor on op/in1/in2 after a go handshake, then raises done.
- This block arbitrates round-robin, latches the winner's operands, sequences go/done, and returns the registered result with a one-cycle ack.
- A watchdog recovers from a DP_CU that never raises done.

Parameters:
- W, 3, operand/result width (matches DP_CU in1/in2/out).
- OPW, 2, opcode width (00 add, 01 sub, 10 and, 11 xor).
- MAX_WAIT, 12, cycles in WAIT before timeout; legal range 1..15 (4-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request level from requester 0 / 1.
- op0 / op1  in  OPW  opcode from requester 0 / 1; must be stable while its req is high.
- a0, b0 / a1, b1  in  W  operands from requester 0 / 1.
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1.
- res0 / res1  out  W  registered result for requester 0 / 1; held until the next ack to the same port.
- dp_go  out  1  go to DP_CU.
- dp_op  out  OPW  op to DP_CU.
- dp_in1, dp_in2  out  W  operands to DP_CU.
- dp_done  in  1  done from DP_CU.
- dp_out  in  W  result from DP_CU.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky; set on watchdog expiry, cleared only by rst_n.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; watchdog counter 0.
- rst_n low mid-operation: dp_go drops immediately (async); no ack is issued; the in-flight request is dropped. A requester still holding req is re-arbitrated after release.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Launch only if (req0|req1) && !dp_done.
  - Winner: the sole requester; if both request, the port != last_grant.
  - At the launch edge: latch winner's op/a/b into dp_op/dp_in1/dp_in2, set grant and last_grant = winner, clear counter, go to WAIT.
- WAIT:
  - dp_go=1; dp_op/dp_in1/dp_in2 held constant; counter increments each cycle.
  - dp_done=1 at an edge: capture dp_out into res[grant], go to RESP.
  - Else if counter == MAX_WAIT-1: res[grant]=0, timeout=1, go to RESP.
  - If done and expiry coincide, done wins: the result is captured and timeout is not set.
- RESP:
  - dp_go=0; ack[grant]=1 for exactly this cycle; next state IDLE unconditionally.
  - The dp_go-low cycle lets DP_CU leave its done state.
- Latency: request sampled at edge k. dp_go high from k+1. DP_CU done seen at edge m. ack and new res valid in cycle m+1. Next launch possible at edge m+2 at the earliest.
- Fairness: with both req held, grants strictly alternate 0,1,0,1…
- A requester that keeps req high after its ack is treated as a new request.
- ack0 and ack1 are never high together.
- Arithmetic is done by DP_CU only; results are modulo 2^W. This block performs no arithmetic besides the counter.
- Operands from the losing port are ignored until it is granted.

Decomposition:
- Shared package dp_pkg:
  - W, OPW.
  - Opcode constants OP_ADD=00, OP_SUB=01, OP_AND=10, OP_XOR=11.
  - FSM state encoding IDLE=0, WAIT=1, RESP=2.
- One natural sub-module: rr_arb2, a 2-way round-robin pick with last_grant register. Combinational grant, registered pointer update on an enable.
- Watchdog counter and datapath latches stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with random req/dp_done, then release -> ack0=ack1=dp_go=busy=timeout=0, res0=res1=0.
- Single request: req0=1, op0=00, a0=3, b0=4, DP_CU done after 4 cycles -> dp_go high from next edge, dp_in1=3, dp_in2=4; one ack0 pulse; res0=7; busy low the cycle after ack.
- Tie: req0 and req1 rise together; op0=01, a0=2, b0=5; op1=11, a1=6, b1=1 -> port 0 served first with res0=5, then port 1 with res1=7; ack1 exactly 2 cycles after its launch edge plus DP latency.
- Fairness: both req held for 6 transactions -> ack order 0,1,0,1,0,1; never both acks in one cycle.
- Watchdog: dp_done tied low, req1=1 -> after 12 WAIT cycles ack1 pulses with res1=0; timeout=1 and stays 1; next request still served normally.
- Reset mid-WAIT: pull rst_n low 2 cycles into WAIT -> dp_go=0 immediately, no ack. After release with req1 and req0 both high, port 0 is granted first.

Source files
------------

// File: rtl/dp_cu_arbiter_pkg.sv
// Shared definitions for the DP_CU arbiter: widths, opcodes and FSM encoding.
package dp_pkg;
   localparam int W   = 3;
   localparam int OPW = 2;

   localparam logic [OPW-1:0] OP_ADD = 2'b00;
   localparam logic [OPW-1:0] OP_SUB = 2'b01;
   localparam logic [OPW-1:0] OP_AND = 2'b10;
   localparam logic [OPW-1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

// File: rtl/dp_cu_arbiter_rr_arb2.sv
// Two-way round-robin pick: combinational grant, last-grant pointer advanced on en_i.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic       gnt_o
);
   logic last_q, last_d;

   always_comb begin
      gnt_o = 1'b0;
      unique case (req_i)
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ~last_q;
         default: gnt_o = 1'b0;
      endcase
      last_d = en_i ? gnt_o : last_q;
   end

   // Pointer starts at 1 so that port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
endmodule

// File: rtl/dp_cu_arbiter.sv
// Shares one DP_CU between two requesters: round-robin launch, go/done sequencing,
// registered per-port results with a one-cycle ack, and a watchdog on missing done.
module dp_cu_arbiter
   import dp_pkg::*;
#(
   parameter int MAX_WAIT = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_i,
   input  logic           req1_i,
   input  logic [OPW-1:0] op0_i,
   input  logic [OPW-1:0] op1_i,
   input  logic [W-1:0]   a0_i,
   input  logic [W-1:0]   b0_i,
   input  logic [W-1:0]   a1_i,
   input  logic [W-1:0]   b1_i,
   output logic           ack0_o,
   output logic           ack1_o,
   output logic [W-1:0]   res0_o,
   output logic [W-1:0]   res1_o,
   output logic           dp_go_o,
   output logic [OPW-1:0] dp_op_o,
   output logic [W-1:0]   dp_in1_o,
   output logic [W-1:0]   dp_in2_o,
   input  logic           dp_done_i,
   input  logic [W-1:0]   dp_out_i,
   output logic           busy_o,
   output logic           timeout_o
);
   localparam logic [3:0] CNT_LAST = 4'(MAX_WAIT - 1);

   state_e         state_q, state_d;
   logic           grant_q, grant_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [OPW-1:0] op_q, op_d;
   logic [W-1:0]   in1_q, in1_d, in2_q, in2_d;
   logic [W-1:0]   res0_q, res0_d, res1_q, res1_d;
   logic           to_q, to_d;
   logic           win, launch;

   // A done still asserted from the previous job blocks a new launch.
   assign launch = (state_q == IDLE) && (req0_i || req1_i) && !dp_done_i;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i ({req1_i, req0_i}),
      .en_i  (launch),
      .gnt_o (win)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      to_d    = to_q;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               op_d    = win ? op1_i : op0_i;
               in1_d   = win ? a1_i  : a0_i;
               in2_d   = win ? b1_i  : b0_i;
               grant_d = win;
               cnt_d   = 4'd0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 4'd1;
            // done takes priority over a simultaneous watchdog expiry
            if (dp_done_i) begin
               if (grant_q) res1_d = dp_out_i;
               else         res0_d = dp_out_i;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               if (grant_q) res1_d = '0;
               else         res0_d = '0;
               to_d    = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         cnt_q   <= 4'd0;
         op_q    <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         res0_q  <= '0;
         res1_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
         to_q    <= to_d;
      end
   end

   assign dp_go_o   = (state_q == WAIT);
   assign ack0_o    = (state_q == RESP) && !grant_q;
   assign ack1_o    = (state_q == RESP) &&  grant_q;
   assign busy_o    = (state_q != IDLE);
   assign dp_op_o   = op_q;
   assign dp_in1_o  = in1_q;
   assign dp_in2_o  = in2_q;
   assign res0_o    = res0_q;
   assign res1_o    = res1_q;
   assign timeout_o = to_q;
endmodule

// File: tb/tb_dp_cu_arbiter.sv
// Scoreboard bench for dp_cu_arbiter with a behavioural DP_CU and transaction-level model.
module tb_dp_cu_arbiter;
   import dp_pkg::*;

   localparam int MAXW = 12;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           req0_i = 1'b0, req1_i = 1'b0;
   logic [OPW-1:0] op0_i = '0, op1_i = '0;
   logic [W-1:0]   a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
   logic           ack0_o, ack1_o, dp_go_o, busy_o, timeout_o;
   logic [W-1:0]   res0_o, res1_o, dp_in1_o, dp_in2_o;
   logic [OPW-1:0] dp_op_o;
   logic           dp_done_i = 1'b0;
   logic [W-1:0]   dp_out_i = '0;

   dp_cu_arbiter #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_i(req0_i), .req1_i(req1_i), .op0_i(op0_i), .op1_i(op1_i),
      .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
      .ack0_o(ack0_o), .ack1_o(ack1_o), .res0_o(res0_o), .res1_o(res1_o),
      .dp_go_o(dp_go_o), .dp_op_o(dp_op_o), .dp_in1_o(dp_in1_o), .dp_in2_o(dp_in2_o),
      .dp_done_i(dp_done_i), .dp_out_i(dp_out_i), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int port; int res; int to; int lat; int op; int a; int b;
   } exp_t;

   exp_t exp_q[$];
   int   lat_q[$];
   int   op_t[2][16], a_t[2][16], b_t[2][16], lat_t[32];
   int   m_last = 1, m_to = 0;
   int   n_pass = 0, n_chk = 0;
   int   cyc = 0;
   bit   dp_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int calc(input int op, input int a, input int b);
      case (op & 3)
         0:       return (a + b) & 7;
         1:       return (a - b) & 7;
         2:       return (a & b) & 7;
         default: return (a ^ b) & 7;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // DP_CU stand-in: after go, raises done L cycles later with the spec result; L from lat_q.
   initial begin : dp_model
      int n, L;
      bit started;
      n = 0; L = 0; started = 1'b0;
      forever begin
         @(negedge clk);
         if (!dp_en) begin
            started   = 1'b0;
            dp_done_i = 1'($urandom);
            dp_out_i  = 3'($urandom);
         end else begin
            if (!dp_go_o) begin
               started   = 1'b0;
               dp_done_i = 1'b0;
            end else if (!started) begin
               started = 1'b1;
               n = 0;
               L = (lat_q.size() > 0) ? lat_q.pop_front() : 255;
            end
            if (started && !dp_done_i) begin
               n++;
               if (n == L) begin
                  dp_done_i = 1'b1;
                  dp_out_i  = 3'(calc(int'(dp_op_o), int'(dp_in1_o), int'(dp_in2_o)));
               end else begin
                  dp_out_i = 3'($urandom);
               end
            end
         end
      end
   end

   initial begin : monitor
      bit go_prev, ack_prev;
      int go_cyc;
      exp_t e;
      go_prev = 1'b0; ack_prev = 1'b0; go_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            go_prev = 1'b0; ack_prev = 1'b0;
         end else begin
            if (ack_prev) chk("busy_after_ack", int'(busy_o), 0);
            if (dp_go_o && !go_prev) begin
               go_cyc = cyc;
               chk("launch_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  chk("dp_op", int'(dp_op_o), exp_q[0].op);
                  chk("dp_in1", int'(dp_in1_o), exp_q[0].a);
                  chk("dp_in2", int'(dp_in2_o), exp_q[0].b);
               end
            end
            go_prev = dp_go_o;
            if (ack0_o || ack1_o) begin
               chk("ack_exclusive", int'(ack0_o & ack1_o), 0);
               chk("ack_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("ack_port", ack1_o ? 1 : 0, e.port);
                  chk("res", e.port ? int'(res1_o) : int'(res0_o), e.res);
                  chk("timeout_at_ack", int'(timeout_o), e.to);
                  chk("latency", cyc - go_cyc, e.lat);
               end
            end
            ack_prev = ack0_o | ack1_o;
         end
      end
   end

   initial begin : guard
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit");
   end

   task automatic drive(input int p, input int i, input bit r);
      if (p == 0) begin
         req0_i = r; op0_i = 2'(op_t[0][i]); a0_i = 3'(a_t[0][i]); b0_i = 3'(b_t[0][i]);
      end else begin
         req1_i = r; op1_i = 2'(op_t[1][i]); a1_i = 3'(a_t[1][i]); b1_i = 3'(b_t[1][i]);
      end
   endtask

   // Reference: one entry per transaction, timeout when DP latency exceeds the watchdog.
   task automatic expect_push(input int p, input int i, input int L);
      exp_t e;
      e.port = p; e.op = op_t[p][i]; e.a = a_t[p][i]; e.b = b_t[p][i];
      if (L <= MAXW) begin
         e.res = calc(e.op, e.a, e.b); e.lat = L;
      end else begin
         e.res = 0; e.lat = MAXW; m_to = 1;
      end
      e.to = m_to;
      exp_q.push_back(e);
      lat_q.push_back(L);
      m_last = p;
   endtask

   task automatic req_thread(input int p, input int n);
      bit got;
      if (n > 0) drive(p, 0, 1'b1);
      for (int i = 0; i < n; i++) begin
         got = 1'b0;
         for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if ((p == 0) ? ack0_o : ack1_o) begin got = 1'b1; break; end
         end
         if (!got) begin
            chk($sformatf("ack%0d_wait", p), 0, 1);
            drive(p, i, 1'b0);
            return;
         end
         if (i + 1 < n) drive(p, i + 1, 1'b1);
         else           drive(p, i, 1'b0);
      end
   endtask

   task automatic run_batch(input int n0, input int n1);
      int r0, r1, k, p;
      int idx[2];
      r0 = n0; r1 = n1; k = 0; idx[0] = 0; idx[1] = 0;
      while (r0 > 0 || r1 > 0) begin
         if (r0 > 0 && r1 > 0) p = 1 - m_last;
         else                  p = (r0 > 0) ? 0 : 1;
         expect_push(p, idx[p], lat_t[k]);
         k++; idx[p]++;
         if (p == 0) r0--; else r1--;
      end
      fork
         req_thread(0, n0);
         req_thread(1, n1);
      join
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic fill_rand(input int lat_lo, input int lat_hi);
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 16; i++) begin
            op_t[p][i] = int'($urandom_range(3, 0));
            a_t[p][i]  = int'($urandom_range(7, 0));
            b_t[p][i]  = int'($urandom_range(7, 0));
         end
      for (int i = 0; i < 32; i++) lat_t[i] = int'($urandom_range(lat_hi, lat_lo));
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0; dp_en = 1'b0;
      exp_q.delete(); lat_q.delete();
      m_last = 1; m_to = 0;
      repeat (cycles) begin
         @(negedge clk);
         req0_i = 1'($urandom); req1_i = 1'($urandom);
         op0_i = 2'($urandom); a0_i = 3'($urandom); b0_i = 3'($urandom);
         chk("rst_dp_go", int'(dp_go_o), 0);
      end
      req0_i = 1'b0; req1_i = 1'b0; dp_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ack0", int'(ack0_o), 0);
      chk("rst_ack1", int'(ack1_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_res0", int'(res0_o), 0);
      chk("rst_res1", int'(res1_o), 0);
      chk("rst_dp_go_after", int'(dp_go_o), 0);
   endtask

   initial begin : main
      int n0, n1;
      bit seen;
      #1;
      do_reset(5);

      // single request: 3 + 4 with a 4-cycle DP
      op_t[0][0] = 0; a_t[0][0] = 3; b_t[0][0] = 4; lat_t[0] = 4;
      run_batch(1, 0);

      // simultaneous requests from reset: port 0 first
      do_reset(3);
      op_t[0][0] = 1; a_t[0][0] = 2; b_t[0][0] = 5;
      op_t[1][0] = 3; a_t[1][0] = 6; b_t[1][0] = 1;
      lat_t[0] = 3; lat_t[1] = 5;
      run_batch(1, 1);

      // fairness with both held
      fill_rand(1, 10);
      run_batch(3, 3);

      // latency extremes: minimum, and done on the expiry edge
      fill_rand(1, 10);
      lat_t[0] = 1; lat_t[1] = MAXW;
      run_batch(2, 0);

      repeat (15) begin
         fill_rand(1, MAXW);
         n0 = int'($urandom_range(3, 0));
         n1 = int'($urandom_range(3, 0));
         if (n0 + n1 > 0) run_batch(n0, n1);
      end

      // watchdog: DP never answers
      fill_rand(1, 10);
      lat_t[0] = 255;
      run_batch(0, 1);
      repeat (4) @(negedge clk);
      chk("timeout_sticky", int'(timeout_o), 1);
      fill_rand(1, 10);
      run_batch(1, 0);
      chk("timeout_still_set", int'(timeout_o), 1);

      // reset while waiting on DP
      fill_rand(1, 10);
      expect_push(1, 0, 30);
      drive(1, 0, 1'b1);
      seen = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (dp_go_o) begin seen = 1'b1; break; end
      end
      chk("midwait_go_seen", int'(seen), 1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midwait_go_drop", int'(dp_go_o), 0);
      chk("midwait_busy_drop", int'(busy_o), 0);
      drive(0, 0, 1'b1);
      exp_q.delete(); lat_q.delete();
      m_last = 1; m_to = 0;
      repeat (3) begin
         @(negedge clk);
         chk("midwait_no_ack", int'(ack0_o | ack1_o), 0);
      end
      rst_n = 1'b1;
      run_batch(1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
